// File: rtl/cp0_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl_pkg
// Description : Shared CP0 definitions: register numbers, exception codes,
//               handler address, register layouts and EPC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_ctrl_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Exception codes carried down the pipeline
    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // Address every pipeline register loads when Req fires
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // Implemented SR bits: IM[15:10], EXL[1], IE[0]
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    // Implemented Cause bits: BD[31], IP[15:10], ExcCode[6:2]
    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    // Restart address: a delay-slot instruction restarts at its branch
    function automatic logic [31:0] epc_target(input logic [31:0] pc,
                                               input logic        delay_slot);
        return delay_slot ? (pc - 32'd4) : pc;
    endfunction

    function automatic logic [31:0] pack_sr(input sr_t sr);
        return {16'd0, sr.im, 8'd0, sr.exl, sr.ie};
    endfunction

    function automatic logic [31:0] pack_cause(input cause_t c);
        return {c.bd, 15'd0, c.ip, 3'd0, c.exc_code, 2'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_int_sync.sv
`default_nettype none
// ============================================================================
// Module      : cp0_int_sync
// Description : Two-flop synchronizer for the external interrupt lines.
//               Only instantiated when CP0_INT_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Shift the lines through the two synchronizing stages
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl
// Description : Coprocessor-0 exception/interrupt controller at the M stage.
//               Holds SR, Cause, EPC, PRId; raises Req to flush the pipe.
//               Define CP0_INT_SYNC_EN to pass HWInt through a two-flop
//               synchronizer (2-cycle interrupt latency); otherwise HWInt
//               is used directly.
// Revision    : 1.0 - initial release
// ============================================================================
import cp0_ctrl_pkg::*;

module cp0_ctrl #(
    parameter logic [31:0] PRID = 32'h2021_0701
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic        M_DelaySlot,
    input  logic [4:0]  M_EXCCode,
    input  logic [5:0]  HWInt,
    input  logic        WrEn,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic        Req,
    output logic [31:0] EPCOut
);

    logic [5:0]  hw_int_eff;
    logic        int_req;
    logic        exc_req;
    logic        req;

    sr_t         sr_d, sr_q;
    cause_t      cause_d, cause_q;
    logic [31:0] epc_d, epc_q;

`ifdef CP0_INT_SYNC_EN
    cp0_int_sync #(
        .WIDTH (6)
    ) u_int_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (HWInt),
        .sync_out (hw_int_eff)
    );
`else
    assign hw_int_eff = HWInt;
`endif

    // Request decode; gated by reset so Req stays low while reset is held
    always_comb begin
        int_req = (|(hw_int_eff & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        exc_req = (M_EXCCode != 5'd0) & ~sr_q.exl;
        req     = (int_req | exc_req) & reset;
    end

    // Next-state for SR/Cause/EPC with priority Req > eret > mtc0
    always_comb begin
        sr_d     = sr_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        // Pending lines stay visible even while masked
        cause_d.ip = hw_int_eff;
        if (req) begin
            sr_d.exl         = 1'b1;
            cause_d.bd       = M_DelaySlot;
            cause_d.exc_code = int_req ? 5'(EXC_INT) : M_EXCCode;
            epc_d            = epc_target(M_PC, M_DelaySlot);
        end else if (EXLClr) begin
            sr_d.exl = 1'b0;
        end else if (WrEn) begin
            if (A == CP0_SR) begin
                sr_d.im  = DIn[15:10];
                sr_d.exl = DIn[1];
                sr_d.ie  = DIn[0];
            end else if (A == CP0_EPC) begin
                epc_d = DIn;
            end
        end
    end

    // CP0 state registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // Combinational register read; same-cycle writes are not bypassed
    always_comb begin
        case (A)
            CP0_SR:    DOut = pack_sr(sr_q);
            CP0_CAUSE: DOut = pack_cause(cause_q);
            CP0_EPC:   DOut = epc_q;
            CP0_PRID:  DOut = PRID;
            default:   DOut = 32'd0;
        endcase
    end

    assign Req    = req;
    assign EPCOut = epc_q;

    // Unimplemented SR bits of the write data are intentionally dropped
    logic unused_din;
    assign unused_din = ^{DIn[31:16], DIn[9:2]};

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_ctrl
// Description : Self-checking bench for cp0_ctrl: directed scenarios and
//               random traffic against a register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_ctrl;

    localparam logic [31:0] C_PRID = 32'h2021_0701;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC;
    logic        M_DelaySlot;
    logic [4:0]  M_EXCCode;
    logic [5:0]  HWInt;
    logic        WrEn;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        EXLClr;
    logic [31:0] DOut;
    logic        Req;
    logic [31:0] EPCOut;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural register images
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_ctrl #(.PRID(C_PRID)) dut (
        .clk         (clk),
        .reset       (reset),
        .M_PC        (M_PC),
        .M_DelaySlot (M_DelaySlot),
        .M_EXCCode   (M_EXCCode),
        .HWInt       (HWInt),
        .WrEn        (WrEn),
        .A           (A),
        .DIn         (DIn),
        .EXLClr      (EXLClr),
        .DOut        (DOut),
        .Req         (Req),
        .EPCOut      (EPCOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_int_req();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return reset && (m_int_req() || ((M_EXCCode != 5'd0) && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return C_PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle(input logic [4:0] a);
        M_PC = 32'h0000_3000; M_DelaySlot = 1'b0; M_EXCCode = 5'd0;
        WrEn = 1'b0; A = a; DIn = 32'd0; EXLClr = 1'b0;
    endtask

    // Check outputs against the model, then advance one clock edge.
    // Entered just after a falling edge with inputs already applied.
    task automatic cycle();
        logic [31:0] n_sr, n_cause, n_epc;
        #1;
        chk("req", {31'd0, Req}, {31'd0, m_req()});
        chk("epcout", EPCOut, m_epc);
        chk("dout", DOut, m_read(A));
        n_sr    = m_sr;
        n_epc   = m_epc;
        n_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
        if (m_req()) begin
            n_sr    = m_sr | 32'h2;
            n_cause = (n_cause & 32'h0000_FC00) | (32'(M_DelaySlot) << 31)
                    | (32'(m_int_req() ? 5'd0 : M_EXCCode) << 2);
            n_epc   = M_DelaySlot ? M_PC - 32'd4 : M_PC;
        end else if (EXLClr) begin
            n_sr = m_sr & ~32'h2;
        end else if (WrEn) begin
            if (A == 5'd12) n_sr  = DIn & 32'h0000_FC03;
            if (A == 5'd14) n_epc = DIn;
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] codes [5];
        codes = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

        // ---------------- reset ----------------
        reset = 1'b0; HWInt = 6'd0; idle(5'd15);
        m_sr = 0; m_cause = 0; m_epc = 0;
        @(negedge clk);
        #1;
        chk("rst_prid", DOut, C_PRID);
        chk("rst_req", {31'd0, Req}, 32'd0);
        chk("rst_epcout", EPCOut, 32'd0);
        A = 5'd12; #1; chk("rst_sr", DOut, 32'd0);
        A = 5'd13; #1; chk("rst_cause", DOut, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- exception, normal slot ----------------
        idle(5'd0); M_EXCCode = 5'd12; M_PC = 32'h3008;
        #1; chk("ov_req", {31'd0, Req}, 32'd1);
        cycle();
        idle(5'd14); #1;
        chk("ov_epc", DOut, 32'h3008);
        chk("ov_req_after", {31'd0, Req}, 32'd0);
        cycle();
        idle(5'd13); #1; chk("ov_cause", DOut, 32'h0000_0030); cycle();
        idle(5'd12); #1; chk("ov_sr", DOut, 32'h0000_0002); cycle();
        idle(5'd0); EXLClr = 1'b1; cycle();
        idle(5'd12); #1; chk("eret_sr", DOut, 32'd0); cycle();

        // ---------------- exception, delay slot ----------------
        idle(5'd0); M_EXCCode = 5'd10; M_PC = 32'h3010; M_DelaySlot = 1'b1; cycle();
        idle(5'd14); #1; chk("ds_epc", DOut, 32'h300C); cycle();
        idle(5'd13); #1; chk("ds_cause", DOut, 32'h8000_0028); cycle();
        idle(5'd0); EXLClr = 1'b1; cycle();

        // ---------------- interrupt beats exception ----------------
        idle(5'd12); WrEn = 1'b1; DIn = 32'h0000_0401; cycle();
        idle(5'd0); HWInt = 6'b000001; M_EXCCode = 5'd4; M_PC = 32'h4000;
        #1; chk("int_req", {31'd0, Req}, 32'd1);
        cycle();
        idle(5'd13); #1; chk("int_cause", DOut, 32'h0000_0400); cycle();
        idle(5'd0); HWInt = 6'd0; EXLClr = 1'b1; cycle();

        // ---------------- masked interrupt ----------------
        idle(5'd12); WrEn = 1'b1; DIn = 32'h0000_0403; cycle();
        idle(5'd0); HWInt = 6'b000001;
        #1; chk("mask_req", {31'd0, Req}, 32'd0);
        cycle();
        idle(5'd13); #1; chk("mask_ip", DOut[15:10], 32'd1); cycle();
        idle(5'd0); EXLClr = 1'b1; #1; chk("mask_eret_req", {31'd0, Req}, 32'd0); cycle();
        idle(5'd0); #1; chk("unmask_req", {31'd0, Req}, 32'd1); cycle();
        idle(5'd0); HWInt = 6'd0; EXLClr = 1'b1; cycle();

        // ---------------- mtc0 squashed / Cause read-only ----------------
        idle(5'd14); WrEn = 1'b1; DIn = 32'h1234; M_EXCCode = 5'd8; M_PC = 32'h5000; cycle();
        idle(5'd14); #1; chk("squash_epc", DOut, 32'h5000); cycle();
        idle(5'd0); EXLClr = 1'b1; cycle();
        idle(5'd13); WrEn = 1'b1; DIn = 32'hFFFF_FFFF; cycle();
        idle(5'd13); #1; chk("cause_ro", DOut, 32'h0000_0020); cycle();

        // ---------------- delay-slot wrap at PC 0 ----------------
        idle(5'd0); M_EXCCode = 5'd5; M_PC = 32'h0; M_DelaySlot = 1'b1; cycle();
        idle(5'd0); #1; chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
        EXLClr = 1'b1; cycle();

        // ---------------- random traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            M_PC        = $urandom & 32'hFFFF_FFFC;
            M_DelaySlot = ($urandom_range(3) == 0);
            M_EXCCode   = ($urandom_range(4) == 0) ? codes[$urandom_range(4)] : 5'd0;
            HWInt       = ($urandom_range(7) == 0) ? 6'($urandom) : 6'd0;
            WrEn        = ($urandom_range(3) == 0);
            A           = 5'(10 + $urandom_range(7));
            DIn         = $urandom;
            EXLClr      = ($urandom_range(3) == 0);
            cycle();
        end

        // ---------------- reset mid-handler ----------------
        HWInt = 6'd0;
        idle(5'd12); WrEn = 1'b1; DIn = 32'h0; cycle();
        idle(5'd0); M_EXCCode = 5'd8; M_PC = 32'h6004; cycle();
        idle(5'd12); #1; chk("pre_rst_exl", DOut, 32'h2);
        M_EXCCode = 5'd8;
        #2 reset = 1'b0;
        #1;
        m_sr = 0; m_cause = 0; m_epc = 0;
        chk("arst_sr", DOut, 32'd0);
        chk("arst_req", {31'd0, Req}, 32'd0);
        chk("arst_epcout", EPCOut, 32'd0);
        A = 5'd13; #1; chk("arst_cause", DOut, 32'd0);
        A = 5'd15; #1; chk("arst_prid", DOut, C_PRID);
        @(negedge clk);
        reset = 1'b1;
        idle(5'd14); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit so the bench can never hang
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
